// File: rtl/dff_share_arbiter_if.sv
// Requester/response bundle for dff_share_arbiter. The arbiter uses the slave
// modport; stimulus agents and the response consumer use master.
interface dff_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 32
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_data;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter sharing one DW-bit capture register among NREQ requesters.
// Optional response-stall timeout is enabled by defining ARB_TIMEOUT_EN.

// Per-requester slice: flags requesters above the rotation pointer and gates
// this requester's word onto the shared OR-mux when selected.
module dff_share_arbiter_lane #(
  parameter int IDX = 0,
  parameter int IDW = 2,
  parameter int DW  = 32
) (
  input  logic [IDW-1:0] ptr,
  input  logic           vld,
  input  logic           sel,
  input  logic [DW-1:0]  word,
  output logic           hi_vld,
  output logic [DW-1:0]  sel_word
);
  assign hi_vld   = vld && (IDW'(IDX) > ptr);
  assign sel_word = sel ? word : '0;
endmodule

module dff_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 32,
  parameter int LAT     = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  dff_share_arbiter_if.slave  bus,
  output logic                busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                timeout_err
`endif
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((LAT > 0) ? LAT - 1 : 0);

  if (NREQ < 2 || NREQ > 16 || LAT < 0 || LAT > 255 || TIMEOUT < 1) begin : g_param_err
    $error("dff_share_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  data_q, data_d;
  logic [IDW-1:0] id_q, id_d;

`ifdef ARB_TIMEOUT_EN
  localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);
  logic [SW-1:0] stall_q, stall_d;
  logic          terr_q, terr_d;
`endif

  logic [NREQ-1:0][DW-1:0] req_words;
  logic [NREQ-1:0][DW-1:0] lane_word;
  logic [NREQ-1:0]         hi_vld;
  logic [NREQ-1:0]         cand;
  logic [NREQ-1:0]         sel_oh;
  logic [IDW-1:0]          win_id;
  logic [DW-1:0]           win_word;
  logic                    found;
  logic                    accept;

  assign req_words = bus.req_data;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    dff_share_arbiter_lane #(.IDX(i), .IDW(IDW), .DW(DW)) u_lane (
      .ptr      (ptr_q),
      .vld      (bus.req_valid[i]),
      .sel      (sel_oh[i]),
      .word     (req_words[i]),
      .hi_vld   (hi_vld[i]),
      .sel_word (lane_word[i])
    );
  end

  // Rotation as two-pass priority: anything above ptr wins first, else wrap to lowest.
  always_comb begin
    cand   = (|hi_vld) ? hi_vld : bus.req_valid;
    sel_oh = '0;
    win_id = '0;
    found  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && cand[i]) begin
        found     = 1'b1;
        sel_oh[i] = 1'b1;
        win_id    = IDW'(i);
      end
    end
  end

  always_comb begin
    win_word = '0;
    for (int i = 0; i < NREQ; i++) win_word = win_word | lane_word[i];
  end

  assign accept = (state_q == S_IDLE) && (|bus.req_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      cnt_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
`ifdef ARB_TIMEOUT_EN
      stall_q <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      id_q    <= id_d;
`ifdef ARB_TIMEOUT_EN
      stall_q <= stall_d;
      terr_q  <= terr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    id_d    = id_q;
`ifdef ARB_TIMEOUT_EN
    stall_d = '0;
    terr_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          data_d  = win_word;
          id_d    = win_id;
          ptr_d   = win_id;
          cnt_d   = '0;
          state_d = (LAT == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) state_d = S_RESP;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        // A handshake in the limit cycle is not a stall, so it wins over the drop.
        else if (stall_q == STALL_LAST) begin
          state_d = S_IDLE;
          terr_d  = 1'b1;
        end else begin
          stall_d = stall_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == S_IDLE && !rst) ? sel_oh : '0;
    bus.rsp_valid = (state_q == S_RESP);
    bus.rsp_id    = id_q;
    bus.rsp_data  = data_q;
    busy          = (state_q != S_IDLE);
`ifdef ARB_TIMEOUT_EN
    timeout_err   = terr_q;
`endif
  end
endmodule
